// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: register address geometry,
// port encoding and small decode helpers.
package regfile_write_arbiter_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic grant_a;
        logic grant_b;
    } grant_t;

    // x0 is hardwired to zero, so a write there is consumed but never enabled.
    function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

    // Round-robin pick between two holding slots; `last` is the most recent winner.
    function automatic grant_t rr_grant(input logic a_full, input logic b_full,
                                        input port_e last);
        grant_t g;
        g = '0;
        unique case ({a_full, b_full})
            2'b10:   g.grant_a = 1'b1;
            2'b01:   g.grant_b = 1'b1;
            2'b11: begin
                if (last == PORT_A) begin
                    g.grant_b = 1'b1;
                end else begin
                    g.grant_a = 1'b1;
                end
            end
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot: full bit plus address/data, with two read-address
// comparators used for hazard detection.
module wb_slot
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [W-1:0]          data_i,
    input  logic [REG_ADDR_W-1:0] cmp1_i,
    input  logic [REG_ADDR_W-1:0] cmp2_i,
    output logic                  full_o,
    output logic [REG_ADDR_W-1:0] addr_o,
    output logic [W-1:0]          data_o,
    output logic                  hit1_o,
    output logic                  hit2_o
);

    logic                  full_q, full_d;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [W-1:0]          data_q;

    // A load in the same cycle as a drain keeps the slot full with the new entry.
    always_comb begin
        full_d = full_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            if (load_i && !clear_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign hit1_o = full_q && (addr_q == cmp1_i);
    assign hit2_o = full_q && (addr_q == cmp2_i);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between an execute (A) and a load (B)
// writeback source using per-port holding slots and a round-robin drain.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [W-1:0]          a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [W-1:0]          b_data,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] Read1,
    input  logic [REG_ADDR_W-1:0] Read2,
    output logic                  Hazard1,
    output logic                  Hazard2,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [W-1:0]          WriteData
);

    logic                  a_full, b_full;
    logic [REG_ADDR_W-1:0] a_slot_addr, b_slot_addr;
    logic [W-1:0]          a_slot_data, b_slot_data;
    logic                  a_hit1, a_hit2, b_hit1, b_hit2;
    logic                  a_accept, b_accept;
    logic                  grant_a, grant_b;
    grant_t                rr;

    port_e                 last_q, last_d;
    logic                  reg_write_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [W-1:0]          write_data_q;

    wb_slot #(
        .W (W)
    ) u_slot_a (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (flush),
        .load_i  (a_accept),
        .drain_i (grant_a),
        .addr_i  (a_addr),
        .data_i  (a_data),
        .cmp1_i  (Read1),
        .cmp2_i  (Read2),
        .full_o  (a_full),
        .addr_o  (a_slot_addr),
        .data_o  (a_slot_data),
        .hit1_o  (a_hit1),
        .hit2_o  (a_hit2)
    );

    wb_slot #(
        .W (W)
    ) u_slot_b (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (flush),
        .load_i  (b_accept),
        .drain_i (grant_b),
        .addr_i  (b_addr),
        .data_i  (b_data),
        .cmp1_i  (Read1),
        .cmp2_i  (Read2),
        .full_o  (b_full),
        .addr_o  (b_slot_addr),
        .data_o  (b_slot_data),
        .hit1_o  (b_hit1),
        .hit2_o  (b_hit2)
    );

    // Grant depends only on registered state; flush suppresses it so nothing drains.
    always_comb begin
        rr      = rr_grant(a_full, b_full, last_q);
        grant_a = rr.grant_a && !flush;
        grant_b = rr.grant_b && !flush;
    end

    assign a_ready  = !flush && (!a_full || grant_a);
    assign b_ready  = !flush && (!b_full || grant_b);
    assign a_accept = a_valid && a_ready;
    assign b_accept = b_valid && b_ready;

    always_comb begin
        last_d = last_q;
        if (grant_a) begin
            last_d = PORT_A;
        end else if (grant_b) begin
            last_d = PORT_B;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q       <= PORT_B;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            last_q <= last_d;
            if (grant_a) begin
                reg_write_q  <= is_writable(a_slot_addr);
                write_reg_q  <= a_slot_addr;
                write_data_q <= a_slot_data;
            end else if (grant_b) begin
                reg_write_q  <= is_writable(b_slot_addr);
                write_reg_q  <= b_slot_addr;
                write_data_q <= b_slot_data;
            end else begin
                reg_write_q  <= 1'b0;
            end
        end
    end

    assign RegWrite  = reg_write_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;

    // The output stage counts as in flight until the register file has taken it.
    assign Hazard1 = is_writable(Read1) &&
                     (a_hit1 || b_hit1 || (reg_write_q && (write_reg_q == Read1)));
    assign Hazard2 = is_writable(Read2) &&
                     (a_hit2 || b_hit2 || (reg_write_q && (write_reg_q == Read2)));

    grant_onehot: assert property (@(posedge clock) disable iff (reset)
        !(grant_a && grant_b));

    flush_blocks_ready: assert property (@(posedge clock) disable iff (reset)
        flush |-> (!a_ready && !b_ready));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file on its outputs.
module tb_regfile_write_arbiter;

    localparam int unsigned W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         a_valid, b_valid, a_ready, b_ready;
    logic [4:0]   a_addr, b_addr;
    logic [W-1:0] a_data, b_data;
    logic         flush;
    logic [4:0]   Read1, Read2;
    logic         Hazard1, Hazard2;
    logic         RegWrite;
    logic [4:0]   WriteReg;
    logic [W-1:0] WriteData;

    logic [W-1:0] rf [32];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clock = ~clock;

    regfile_write_arbiter #(
        .W (W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .flush     (flush),
        .Read1     (Read1),
        .Read2     (Read2),
        .Hazard1   (Hazard1),
        .Hazard2   (Hazard2),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData)
    );

    // Register file sitting beside the arbiter, as in the datapath.
    always_ff @(posedge clock) begin
        if (RegWrite && WriteReg != 5'd0) begin
            rf[WriteReg] <= WriteData;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        flush   = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        Read1 = '0; Read2 = '0;

        // Reset state and a lone write from A.
        apply_reset();
        check_eq("rst_regwrite", RegWrite, 0);
        check_eq("rst_writereg", WriteReg, 0);
        check_eq("rst_writedata", WriteData, 0);
        check_eq("rst_a_ready", a_ready, 1);
        check_eq("rst_b_ready", b_ready, 1);
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF; Read1 = 5'd5;
        #1;
        check_eq("t1_haz_before", Hazard1, 0);
        tick();
        a_valid = 1'b0;
        #1;
        check_eq("t1_haz_slot", Hazard1, 1);
        check_eq("t1_regwrite_early", RegWrite, 0);
        tick();
        check_eq("t1_regwrite", RegWrite, 1);
        check_eq("t1_writereg", WriteReg, 5);
        check_eq("t1_writedata", WriteData, 32'hDEADBEEF);
        check_eq("t1_haz_out", Hazard1, 1);
        tick();
        check_eq("t1_regwrite_off", RegWrite, 0);
        check_eq("t1_haz_clear", Hazard1, 0);
        check_eq("t1_rf5", rf[5], 32'hDEADBEEF);

        // Contention: alternation A, B, A, B with readies pulsing every other cycle.
        apply_reset();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd1;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'd2;
        tick();
        for (int k = 1; k <= 4; k++) begin
            check_eq($sformatf("t2_a_ready_%0d", k), a_ready, (k % 2 == 1) ? 1 : 0);
            check_eq($sformatf("t2_b_ready_%0d", k), b_ready, (k % 2 == 0) ? 1 : 0);
            if (k >= 2) begin
                check_eq($sformatf("t2_writereg_%0d", k), WriteReg, (k % 2 == 0) ? 3 : 4);
            end
            tick();
        end
        check_eq("t2_writereg_5", WriteReg, 4);
        check_eq("t2_regwrite_5", RegWrite, 1);
        a_valid = 1'b0; b_valid = 1'b0;

        // Same destination from both ports: A commits first, B last.
        apply_reset();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h22;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        check_eq("t3_first_data", WriteData, 32'h11);
        tick();
        check_eq("t3_rf7_mid", rf[7], 32'h11);
        check_eq("t3_second_data", WriteData, 32'h22);
        tick();
        check_eq("t3_rf7_final", rf[7], 32'h22);

        // Write to x0 drains but never enables the register file.
        apply_reset();
        Read1 = 5'd0;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFF;
        #1;
        check_eq("t4_b_ready", b_ready, 1);
        tick();
        b_valid = 1'b0;
        #1;
        check_eq("t4_b_ready_drain", b_ready, 1);
        check_eq("t4_haz_slot", Hazard1, 0);
        tick();
        check_eq("t4_regwrite", RegWrite, 0);
        check_eq("t4_writedata", WriteData, 32'hFF);
        check_eq("t4_haz_out", Hazard1, 0);

        // Flush with both slots full and a write sitting in the output register.
        apply_reset();
        a_valid = 1'b1; a_addr = 5'd10; a_data = 32'hA0;
        b_valid = 1'b1; b_addr = 5'd11; b_data = 32'hB0;
        tick();
        a_addr = 5'd12; a_data = 32'hC0;
        b_addr = 5'd13; b_data = 32'hD0;
        tick();
        a_valid = 1'b0;
        #1;
        check_eq("t5_b_ready_pre", b_ready, 1);
        tick();
        b_valid = 1'b0;
        flush = 1'b1; Read1 = 5'd12; Read2 = 5'd13;
        #1;
        check_eq("t5_regwrite_pending", RegWrite, 1);
        check_eq("t5_writereg_pending", WriteReg, 11);
        check_eq("t5_a_ready_flush", a_ready, 0);
        check_eq("t5_b_ready_flush", b_ready, 0);
        check_eq("t5_haz1_full", Hazard1, 1);
        check_eq("t5_haz2_full", Hazard2, 1);
        tick();
        flush = 1'b0;
        #1;
        check_eq("t5_regwrite_after", RegWrite, 0);
        check_eq("t5_haz1_after", Hazard1, 0);
        check_eq("t5_haz2_after", Hazard2, 0);
        check_eq("t5_a_ready_after", a_ready, 1);
        check_eq("t5_b_ready_after", b_ready, 1);
        check_eq("t5_rf11", rf[11], 32'hB0);
        check_eq("t5_writereg_hold", WriteReg, 11);
        Read1 = '0; Read2 = '0;

        // Streaming from A, then an asynchronous reset mid-stream.
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            a_valid = 1'b1; a_addr = 5'(k); a_data = 32'(k * 16);
            #1;
            check_eq($sformatf("t6_a_ready_%0d", k), a_ready, 1);
            tick();
            if (k >= 2) begin
                check_eq($sformatf("t6_regwrite_%0d", k), RegWrite, 1);
                check_eq($sformatf("t6_writereg_%0d", k), WriteReg, k - 1);
            end
        end
        Read1 = 5'd4;
        #1;
        check_eq("t6_haz_pre", Hazard1, 1);
        #1 reset = 1'b1;
        #1;
        check_eq("t6_rst_regwrite", RegWrite, 0);
        check_eq("t6_rst_writereg", WriteReg, 0);
        check_eq("t6_rst_writedata", WriteData, 0);
        check_eq("t6_rst_haz", Hazard1, 0);
        a_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check_eq("t6_a_ready_rel", a_ready, 1);
        check_eq("t6_b_ready_rel", b_ready, 1);
        a_valid = 1'b1; a_addr = 5'd20; a_data = 32'h20;
        b_valid = 1'b1; b_addr = 5'd21; b_data = 32'h21;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check_eq("t6_grant_a_ready", a_ready, 1);
        check_eq("t6_grant_b_ready", b_ready, 0);
        tick();
        check_eq("t6_first_writereg", WriteReg, 20);
        check_eq("t6_first_writedata", WriteData, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
